// File: rtl/ecc_operand_bank.sv
// ecc_operand_bank
// Operand/result store and run sequencer for the P-256 point-multiply core.
// The host side loads K/GX/GY and reads back RX/RY one byte at a time.
// The core side reads k/gx/gy words with one-cycle latency and writes rx/ry words.
// A small FSM issues the start pulse, follows the core_rdy handshake and reports status.
module ecc_operand_bank #(
   parameter int unsigned pWORD_W        = 32,
   parameter int unsigned pNUM_WORDS     = 8,
   parameter int unsigned pSTART_TIMEOUT = 15
) (
   input  logic                          clk,
   input  logic                          reset_i,
   input  logic [2:0]                    host_bank,
   input  logic [4:0]                    host_bytecnt,
   input  logic [7:0]                    host_wdata,
   input  logic                          host_write,
   input  logic                          host_read,
   output logic [7:0]                    host_rdata,
   input  logic [$clog2(pNUM_WORDS)-1:0] k_addr,
   input  logic [$clog2(pNUM_WORDS)-1:0] gx_addr,
   input  logic [$clog2(pNUM_WORDS)-1:0] gy_addr,
   output logic [pWORD_W-1:0]            k_word,
   output logic [pWORD_W-1:0]            gx_word,
   output logic [pWORD_W-1:0]            gy_word,
   input  logic [$clog2(pNUM_WORDS)-1:0] rx_addr,
   input  logic [$clog2(pNUM_WORDS)-1:0] ry_addr,
   input  logic                          rx_wren,
   input  logic                          ry_wren,
   input  logic [pWORD_W-1:0]            rx_word,
   input  logic [pWORD_W-1:0]            ry_word,
   input  logic                          core_rdy,
   output logic                          O_start,
   output logic                          O_busy
);

   localparam int unsigned AW     = $clog2(pNUM_WORDS);
   localparam int unsigned BPW    = pWORD_W / 8;
   localparam int unsigned LANE_W = $clog2(BPW);
   localparam int unsigned CNT_W  = $clog2(pSTART_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_WAIT_FALL = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_CHECK     = 3'd4;

   localparam logic [2:0] BANK_K    = 3'd0;
   localparam logic [2:0] BANK_GX   = 3'd1;
   localparam logic [2:0] BANK_GY   = 3'd2;
   localparam logic [2:0] BANK_RX   = 3'd3;
   localparam logic [2:0] BANK_RY   = 3'd4;
   localparam logic [2:0] BANK_CTRL = 3'd5;

   // operand storage, one word per entry
   logic [pWORD_W-1:0] k_q  [pNUM_WORDS];
   logic [pWORD_W-1:0] gx_q [pNUM_WORDS];
   logic [pWORD_W-1:0] gy_q [pNUM_WORDS];
   logic [pWORD_W-1:0] rx_q [pNUM_WORDS];
   logic [pWORD_W-1:0] ry_q [pNUM_WORDS];

   logic [pWORD_W-1:0] k_word_q, gx_word_q, gy_word_q;
   logic [7:0]         host_rdata_q, host_rdata_d;

   logic [pNUM_WORDS-1:0] rx_mask_q, rx_mask_d;
   logic [pNUM_WORDS-1:0] ry_mask_q, ry_mask_d;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             result_valid_q, result_valid_d;
   logic             start_err_q, start_err_d;
   logic             mask_clr;

   logic [LANE_W-1:0] host_lane;
   logic [AW-1:0]     host_widx;
   logic              host_op_wr;
   logic              start_req;
   logic              rv_clr;
   logic              err_clr;

   // byte b of an operand lives in word b/BPW, lane b%BPW
   assign host_lane = host_bytecnt[LANE_W-1:0];
   assign host_widx = host_bytecnt[LANE_W +: AW];

   assign host_op_wr = host_write && (state_q == S_IDLE);
   assign start_req  = host_op_wr && (host_bank == BANK_CTRL) && host_wdata[0];
   assign err_clr    = host_write && (host_bank == BANK_CTRL) && host_wdata[1];
   assign rv_clr     = err_clr || (host_write && (host_bank == BANK_K));

   assign O_busy     = (state_q != S_IDLE);
   assign O_start    = (state_q == S_START);
   assign host_rdata = host_rdata_q;
   assign k_word     = k_word_q;
   assign gx_word    = gx_word_q;
   assign gy_word    = gy_word_q;

   function automatic logic [pWORD_W-1:0] put_byte(input logic [pWORD_W-1:0] w,
                                                   input logic [LANE_W-1:0]  lane,
                                                   input logic [7:0]         b);
      logic [pWORD_W-1:0] r;
      r = w;
      for (int unsigned l = 0; l < BPW; l++) begin
         if (lane == l[LANE_W-1:0]) begin
            r[8*l +: 8] = b;
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] get_byte(input logic [pWORD_W-1:0] w,
                                           input logic [LANE_W-1:0]  lane);
      logic [7:0] r;
      r = '0;
      for (int unsigned l = 0; l < BPW; l++) begin
         if (lane == l[LANE_W-1:0]) begin
            r = w[8*l +: 8];
         end
      end
      return r;
   endfunction

   // host byte loads of K/GX/GY, accepted only while idle
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < pNUM_WORDS; i++) begin
            k_q[i]  <= '0;
            gx_q[i] <= '0;
            gy_q[i] <= '0;
         end
      end else if (host_op_wr) begin
         case (host_bank)
            BANK_K:  k_q[host_widx]  <= put_byte(k_q[host_widx], host_lane, host_wdata);
            BANK_GX: gx_q[host_widx] <= put_byte(gx_q[host_widx], host_lane, host_wdata);
            BANK_GY: gy_q[host_widx] <= put_byte(gy_q[host_widx], host_lane, host_wdata);
            default: ;
         endcase
      end
   end

   // core word reads, one-cycle latency, no enable
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         k_word_q  <= '0;
         gx_word_q <= '0;
         gy_word_q <= '0;
      end else begin
         k_word_q  <= k_q[k_addr];
         gx_word_q <= gx_q[gx_addr];
         gy_word_q <= gy_q[gy_addr];
      end
   end

   // core result word writes, accepted in any state
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < pNUM_WORDS; i++) begin
            rx_q[i] <= '0;
            ry_q[i] <= '0;
         end
      end else begin
         if (rx_wren) begin
            rx_q[rx_addr] <= rx_word;
         end
         if (ry_wren) begin
            ry_q[ry_addr] <= ry_word;
         end
      end
   end

   // written-word masks; a start clears them even if a write lands the same cycle
   always_comb begin
      rx_mask_d = rx_mask_q;
      ry_mask_d = ry_mask_q;
      if (rx_wren) begin
         rx_mask_d[rx_addr] = 1'b1;
      end
      if (ry_wren) begin
         ry_mask_d[ry_addr] = 1'b1;
      end
      if (mask_clr) begin
         rx_mask_d = '0;
         ry_mask_d = '0;
      end
   end

   // host read mux; the registered output gives pre-write data on a simultaneous write
   always_comb begin
      host_rdata_d = '0;
      case (host_bank)
         BANK_K:    host_rdata_d = get_byte(k_q[host_widx], host_lane);
         BANK_GX:   host_rdata_d = get_byte(gx_q[host_widx], host_lane);
         BANK_GY:   host_rdata_d = get_byte(gy_q[host_widx], host_lane);
         BANK_RX:   host_rdata_d = get_byte(rx_q[host_widx], host_lane);
         BANK_RY:   host_rdata_d = get_byte(ry_q[host_widx], host_lane);
         BANK_CTRL: host_rdata_d = {5'b0, start_err_q, result_valid_q, O_busy};
         default:   host_rdata_d = '0;
      endcase
   end

   // host read data register, holds its value between reads
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         host_rdata_q <= '0;
      end else if (host_read) begin
         host_rdata_q <= host_rdata_d;
      end
   end

   // run sequencer; FSM outcomes override a same-cycle host flag clear
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      result_valid_d = result_valid_q;
      start_err_d    = start_err_q;
      mask_clr       = 1'b0;
      if (rv_clr) begin
         result_valid_d = 1'b0;
      end
      if (err_clr) begin
         start_err_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               mask_clr       = 1'b1;
               result_valid_d = 1'b0;
               start_err_d    = 1'b0;
               state_d        = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT_FALL;
         end
         S_WAIT_FALL: begin
            if (!core_rdy) begin
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(pSTART_TIMEOUT)) begin
                  start_err_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
         end
         S_RUN: begin
            if (core_rdy) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((&rx_mask_q) && (&ry_mask_q)) begin
               result_valid_d = 1'b1;
            end else begin
               start_err_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // sequencer and status registers
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         result_valid_q <= 1'b0;
         start_err_q    <= 1'b0;
         rx_mask_q      <= '0;
         ry_mask_q      <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         result_valid_q <= result_valid_d;
         start_err_q    <= start_err_d;
         rx_mask_q      <= rx_mask_d;
         ry_mask_q      <= ry_mask_d;
      end
   end

endmodule

// File: tb/tb_ecc_operand_bank.sv
// Directed bench for ecc_operand_bank: operand loads, core read latency,
// host read-back, full and incomplete runs, start timeout, busy lockout, reset.
module tb_ecc_operand_bank;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [2:0]  host_bank;
   logic [4:0]  host_bytecnt;
   logic [7:0]  host_wdata;
   logic        host_write;
   logic        host_read;
   logic [7:0]  host_rdata;
   logic [2:0]  k_addr, gx_addr, gy_addr;
   logic [31:0] k_word, gx_word, gy_word;
   logic [2:0]  rx_addr, ry_addr;
   logic        rx_wren, ry_wren;
   logic [31:0] rx_word, ry_word;
   logic        core_rdy;
   logic        O_start;
   logic        O_busy;

   int checks   = 0;
   int failures = 0;

   ecc_operand_bank #(
      .pWORD_W       (32),
      .pNUM_WORDS    (8),
      .pSTART_TIMEOUT(15)
   ) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .host_bank   (host_bank),
      .host_bytecnt(host_bytecnt),
      .host_wdata  (host_wdata),
      .host_write  (host_write),
      .host_read   (host_read),
      .host_rdata  (host_rdata),
      .k_addr      (k_addr),
      .gx_addr     (gx_addr),
      .gy_addr     (gy_addr),
      .k_word      (k_word),
      .gx_word     (gx_word),
      .gy_word     (gy_word),
      .rx_addr     (rx_addr),
      .ry_addr     (ry_addr),
      .rx_wren     (rx_wren),
      .ry_wren     (ry_wren),
      .rx_word     (rx_word),
      .ry_word     (ry_word),
      .core_rdy    (core_rdy),
      .O_start     (O_start),
      .O_busy      (O_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_wr(input logic [2:0] b, input logic [4:0] c, input logic [7:0] d);
      host_bank    = b;
      host_bytecnt = c;
      host_wdata   = d;
      host_write   = 1'b1;
      tick();
      host_write   = 1'b0;
   endtask

   task automatic host_rd(input logic [2:0] b, input logic [4:0] c, output logic [7:0] d);
      host_bank    = b;
      host_bytecnt = c;
      host_read    = 1'b1;
      tick();
      host_read    = 1'b0;
      d            = host_rdata;
   endtask

   // start a run, drop rdy, write all result words (optionally skipping RY word 5), raise rdy
   task automatic run_core(input bit skip_ry5, input logic [7:0] exp_status);
      logic [7:0] d;
      host_wr(3'd5, 5'd0, 8'h01);
      chk("start_pulse", {31'b0, O_start}, 32'd1);
      chk("busy_in_start", {31'b0, O_busy}, 32'd1);
      tick();
      chk("start_one_cycle", {31'b0, O_start}, 32'd0);
      core_rdy = 1'b0;
      tick();
      tick();
      host_rd(3'd5, 5'd0, d);
      chk("status_busy", {24'b0, d}, 32'h01);
      for (int i = 0; i < 8; i++) begin
         rx_wren = 1'b1;
         rx_addr = 3'(i);
         rx_word = 32'h11111111 * 32'(i + 1);
         ry_wren = !(skip_ry5 && (i == 5));
         ry_addr = 3'(i);
         ry_word = 32'hC0DE0000 | 32'(i);
         tick();
      end
      rx_wren = 1'b0;
      ry_wren = 1'b0;
      host_rd(3'd3, 5'd0, d);
      chk("rx_read_while_busy", {24'b0, d}, 32'h11);
      core_rdy = 1'b1;
      tick();
      chk("busy_in_check", {31'b0, O_busy}, 32'd1);
      tick();
      chk("busy_after_run", {31'b0, O_busy}, 32'd0);
      host_rd(3'd5, 5'd0, d);
      chk("status_after_run", {24'b0, d}, {24'b0, exp_status});
   endtask

   initial begin
      logic [7:0] d;
      reset_i      = 1'b1;
      host_bank    = '0;
      host_bytecnt = '0;
      host_wdata   = '0;
      host_write   = 1'b0;
      host_read    = 1'b0;
      k_addr       = '0;
      gx_addr      = '0;
      gy_addr      = '0;
      rx_addr      = '0;
      ry_addr      = '0;
      rx_wren      = 1'b0;
      ry_wren      = 1'b0;
      rx_word      = '0;
      ry_word      = '0;
      core_rdy     = 1'b1;

      // reset state
      tick();
      tick();
      chk("rst_rdata", {24'b0, host_rdata}, 32'h0);
      chk("rst_k_word", k_word, 32'h0);
      chk("rst_busy", {31'b0, O_busy}, 32'd0);
      chk("rst_start", {31'b0, O_start}, 32'd0);
      reset_i = 1'b0;
      tick();

      // operand loads: K = 0x01, GX word 0 = 0xDEADBEEF, GY = 0
      host_wr(3'd0, 5'd0, 8'h01);
      host_wr(3'd1, 5'd0, 8'hEF);
      host_wr(3'd1, 5'd1, 8'hBE);
      host_wr(3'd1, 5'd2, 8'hAD);
      host_wr(3'd1, 5'd3, 8'hDE);

      // core read latency: address 1 -> 0, data follows one edge later
      k_addr  = 3'd1;
      gx_addr = 3'd1;
      tick();
      k_addr  = 3'd0;
      gx_addr = 3'd0;
      gy_addr = 3'd0;
      chk("k_word_prev_addr", k_word, 32'h0);
      chk("gx_word_prev_addr", gx_word, 32'h0);
      tick();
      chk("k_word_lat1", k_word, 32'h00000001);
      chk("gx_word_lat1", gx_word, 32'hDEADBEEF);
      chk("gy_word_lat1", gy_word, 32'h0);

      // host read-back
      host_rd(3'd0, 5'd0, d);
      chk("k_byte0", {24'b0, d}, 32'h01);
      host_rd(3'd0, 5'd31, d);
      chk("k_byte31", {24'b0, d}, 32'h00);
      host_rd(3'd1, 5'd2, d);
      chk("gx_byte2", {24'b0, d}, 32'hAD);
      host_rd(3'd6, 5'd0, d);
      chk("bank6_zero", {24'b0, d}, 32'h00);

      // complete run
      run_core(1'b0, 8'h02);
      host_wr(3'd3, 5'd0, 8'h77);
      host_rd(3'd3, 5'd0, d);
      chk("rx_write_ignored", {24'b0, d}, 32'h11);
      host_rd(3'd3, 5'd12, d);
      chk("rx_byte12", {24'b0, d}, 32'h44);
      host_rd(3'd4, 5'd31, d);
      chk("ry_byte31", {24'b0, d}, 32'hC0);
      host_rd(3'd4, 5'd28, d);
      chk("ry_byte28", {24'b0, d}, 32'h07);
      host_rd(3'd5, 5'd0, d);
      chk("status_kept", {24'b0, d}, 32'h02);

      // simultaneous read and write returns pre-write data; K write clears result_valid
      host_bank    = 3'd0;
      host_bytecnt = 5'd1;
      host_wdata   = 8'h5A;
      host_write   = 1'b1;
      host_read    = 1'b1;
      tick();
      host_write   = 1'b0;
      host_read    = 1'b0;
      chk("rw_same_cycle", {24'b0, host_rdata}, 32'h00);
      host_rd(3'd0, 5'd1, d);
      chk("rw_new_value", {24'b0, d}, 32'h5A);
      host_rd(3'd5, 5'd0, d);
      chk("k_write_clears_rv", {24'b0, d}, 32'h00);

      // incomplete run: RY word 5 missing
      run_core(1'b1, 8'h04);
      host_wr(3'd5, 5'd0, 8'h02);
      host_rd(3'd5, 5'd0, d);
      chk("flag_clear", {24'b0, d}, 32'h00);

      // start timeout with core_rdy held high
      host_wr(3'd5, 5'd0, 8'h01);
      tick();
      for (int i = 0; i < 14; i++) begin
         tick();
      end
      chk("busy_before_timeout", {31'b0, O_busy}, 32'd1);
      host_rd(3'd5, 5'd0, d);
      chk("status_last_wait", {24'b0, d}, 32'h01);
      chk("busy_after_timeout", {31'b0, O_busy}, 32'd0);
      host_rd(3'd5, 5'd0, d);
      chk("status_timeout", {24'b0, d}, 32'h04);
      host_wr(3'd5, 5'd0, 8'h02);

      // busy lockout, then reset mid-run
      host_wr(3'd5, 5'd0, 8'h01);
      tick();
      core_rdy = 1'b0;
      tick();
      host_wr(3'd0, 5'd0, 8'hFF);
      host_wr(3'd5, 5'd0, 8'h01);
      chk("no_restart_pulse", {31'b0, O_start}, 32'd0);
      chk("busy_in_run", {31'b0, O_busy}, 32'd1);
      host_rd(3'd0, 5'd0, d);
      chk("k_write_ignored", {24'b0, d}, 32'h01);
      reset_i = 1'b1;
      #1;
      chk("async_rst_busy", {31'b0, O_busy}, 32'd0);
      chk("async_rst_k_word", k_word, 32'h0);
      tick();
      reset_i  = 1'b0;
      core_rdy = 1'b1;
      tick();
      host_rd(3'd0, 5'd0, d);
      chk("rst_k_cleared", {24'b0, d}, 32'h00);
      host_rd(3'd1, 5'd3, d);
      chk("rst_gx_cleared", {24'b0, d}, 32'h00);
      host_rd(3'd3, 5'd0, d);
      chk("rst_rx_cleared", {24'b0, d}, 32'h00);
      host_rd(3'd4, 5'd31, d);
      chk("rst_ry_cleared", {24'b0, d}, 32'h00);
      host_rd(3'd5, 5'd0, d);
      chk("rst_status", {24'b0, d}, 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
